// File: rtl/dii_packet_arbiter.sv
// dii_packet_arbiter
//   Round-robin, packet-granular arbiter. It shares one DII port among
//   NUM_PORTS requesters. A grant is held from the first flit of a packet
//   until that packet's last flit is accepted, so packets never interleave.
//   The output goes through a single-entry register stage with full
//   throughput.
// Ports
//   clk, rst      clock, asynchronous active-low reset
//   in_flit       per-port requester flits {valid, last, data[15:0]}
//   in_ready      per-port accept (combinational)
//   out_flit      registered arbitrated flit
//   out_ready     downstream accept
//   grant_idx     port currently or most recently granted
//   busy          high while a multi-flit packet holds the lock
//   err_len       one-cycle pulse when a packet grows past MAX_PKT_LEN flits

package dii_pkg;
    typedef struct packed {
        logic        valid;
        logic        last;
        logic [15:0] data;
    } dii_flit;
endpackage

// Per-port accept. In IDLE the port wins if it is the round-robin pick.
// In LOCKED it wins if it owns the lock. Either way it also needs a free
// output slot and reset released.
module dii_arb_lane (
    input  logic rst,
    input  logic slot_free,
    input  logic idle,
    input  logic hit,
    input  logic is_grant,
    output logic ready
);
    assign ready = rst & slot_free & (idle ? hit : is_grant);
endmodule

module dii_packet_arbiter
    import dii_pkg::*;
#(
    parameter  int NUM_PORTS   = 2,
    parameter  int MAX_PKT_LEN = 12,
    localparam int IW          = $clog2(NUM_PORTS),
    localparam int CW          = $clog2(MAX_PKT_LEN + 2)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  dii_flit [NUM_PORTS-1:0] in_flit,
    output logic    [NUM_PORTS-1:0] in_ready,
    output dii_flit                 out_flit,
    input  logic                    out_ready,
    output logic    [IW-1:0]        grant_idx,
    output logic                    busy,
    output logic                    err_len
);
    typedef enum logic {IDLE, LOCKED} state_t;

    state_t         state, state_nxt;
    logic [IW-1:0]  rr_ptr, rr_nxt, grant_nxt, sel, acc_idx;
    logic [CW-1:0]  pkt_cnt, cnt_nxt;
    logic           found, slot_free, accept, err_nxt;
    dii_flit        acc_flit;

    assign slot_free = !out_flit.valid | out_ready;
    assign busy      = (state == LOCKED);

    // First valid requester, searching upward from rr_ptr with wrap.
    always_comb begin
        int            j;
        logic [IW-1:0] jj;
        sel   = '0;
        found = 1'b0;
        j     = 0;
        jj    = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            j = int'(rr_ptr) + k;
            if (j >= NUM_PORTS) j = j - NUM_PORTS;
            jj = IW'(j);
            if (!found && in_flit[jj].valid) begin
                found = 1'b1;
                sel   = jj;
            end
        end
    end

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_lane
        dii_arb_lane u_lane (
            .rst       (rst),
            .slot_free (slot_free),
            .idle      (state == IDLE),
            .hit       (found && sel == IW'(i)),
            .is_grant  (grant_idx == IW'(i)),
            .ready     (in_ready[i])
        );
    end

    // At most one in_ready is high, and it is always at acc_idx.
    assign acc_idx  = (state == IDLE) ? sel : grant_idx;
    assign acc_flit = in_flit[acc_idx];
    assign accept   = acc_flit.valid & in_ready[acc_idx];

    always_comb begin
        state_nxt = state;
        rr_nxt    = rr_ptr;
        grant_nxt = grant_idx;
        cnt_nxt   = pkt_cnt;
        err_nxt   = 1'b0;
        if (accept) begin
            grant_nxt = acc_idx;
            if (state == IDLE)
                cnt_nxt = CW'(1);
            else if (pkt_cnt != CW'(MAX_PKT_LEN + 1))
                cnt_nxt = pkt_cnt + CW'(1);
            // The counter saturates one past the limit, so this fires once.
            err_nxt = (state == LOCKED) && !acc_flit.last &&
                      (pkt_cnt == CW'(MAX_PKT_LEN));
            if (acc_flit.last) begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
                rr_nxt    = (acc_idx == IW'(NUM_PORTS - 1)) ? '0 : acc_idx + IW'(1);
            end else begin
                state_nxt = LOCKED;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr    <= '0;
            grant_idx <= '0;
            pkt_cnt   <= '0;
            err_len   <= 1'b0;
            out_flit  <= '0;
        end else begin
            rr_ptr    <= rr_nxt;
            grant_idx <= grant_nxt;
            pkt_cnt   <= cnt_nxt;
            err_len   <= err_nxt;
            if (slot_free) out_flit <= accept ? acc_flit : '0;
        end
    end
endmodule

// File: tb/tb_dii_packet_arbiter.sv
// Randomized bench for dii_packet_arbiter. Each port draws its flits from
// its own packet queue. A cycle-level reference model predicts in_ready,
// the output register, busy, grant_idx and err_len. The model tracks the
// lock owner as an int (-1 when no packet holds the lock) and a next-priority
// port.
module tb_dii_packet_arbiter;
    import dii_pkg::*;
    localparam int NP = 4;
    localparam int ML = 12;

    logic             clk = 1'b0;
    logic             rst;
    dii_flit [NP-1:0] in_flit;
    logic    [NP-1:0] in_ready;
    dii_flit          out_flit;
    logic             out_ready;
    logic    [1:0]    grant_idx;
    logic             busy, err_len;

    dii_packet_arbiter #(.NUM_PORTS(NP), .MAX_PKT_LEN(ML)) dut (
        .clk(clk), .rst(rst), .in_flit(in_flit), .in_ready(in_ready),
        .out_flit(out_flit), .out_ready(out_ready), .grant_idx(grant_idx),
        .busy(busy), .err_len(err_len)
    );

    always #5 clk = ~clk;

    int      n_vec = 0, n_miss = 0;
    dii_flit pq[NP][$];
    logic [NP-1:0] mute;

    // reference model state
    dii_flit m_out;
    int      m_owner, m_next, m_grant, m_cnt, err_pulses;
    logic    m_err;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_out = '0; m_owner = -1; m_next = 0; m_grant = 0; m_cnt = 0; m_err = 1'b0;
    endtask

    task automatic add_pkt(input int p, input int len);
        dii_flit f;
        for (int i = 0; i < len; i++) begin
            f.valid = 1'b1;
            f.last  = (i == len - 1);
            f.data  = 16'($urandom);
            pq[p].push_back(f);
        end
    endtask

    function automatic bit pending();
        for (int p = 0; p < NP; p++) if (pq[p].size() > 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic drive(input int vp, input int rp);
        for (int p = 0; p < NP; p++) begin
            if (!mute[p] && pq[p].size() > 0 && int'($urandom_range(99)) < vp)
                in_flit[p] = pq[p][0];
            else begin
                in_flit[p].valid = 1'b0;
                in_flit[p].last  = 1'(($urandom_range(1)));
                in_flit[p].data  = 16'($urandom);
            end
        end
        out_ready = (int'($urandom_range(99)) < rp);
    endtask

    // One clock: drive after the edge, check and advance the model late in
    // the cycle, then move to just after the next rising edge.
    task automatic cycle(input int vp, input int rp);
        logic [NP-1:0] er;
        bit   sf, fnd;
        int   acc, p;
        dii_flit f;
        drive(vp, rp);
        #3;
        er = '0; acc = -1; fnd = 1'b0;
        sf = !m_out.valid || out_ready;
        if (m_owner < 0) begin
            for (int k = 0; k < NP; k++) begin
                p = (m_next + k) % NP;
                if (!fnd && in_flit[p].valid) begin
                    fnd = 1'b1;
                    if (sf) er[p] = 1'b1;
                end
            end
        end else begin
            er[m_owner] = sf;
        end
        chk("in_ready", 32'(in_ready), 32'(er));
        chk("out_valid", 32'(out_flit.valid), 32'(m_out.valid));
        if (m_out.valid) chk("out_flit", 32'(out_flit), 32'(m_out));
        chk("busy", 32'(busy), 32'(m_owner >= 0));
        chk("grant_idx", 32'(grant_idx), 32'(m_grant));
        chk("err_len", 32'(err_len), 32'(m_err));
        if (err_len) err_pulses++;

        for (int q = 0; q < NP; q++) if (er[q] && in_flit[q].valid) acc = q;
        m_err = 1'b0;
        if (sf) m_out = (acc >= 0) ? in_flit[acc] : '0;
        if (acc >= 0) begin
            f = in_flit[acc];
            void'(pq[acc].pop_front());
            m_grant = acc;
            m_cnt++;
            if (m_cnt == ML + 1 && !f.last) m_err = 1'b1;
            if (f.last) begin
                m_owner = -1; m_next = (acc + 1) % NP; m_cnt = 0;
            end else begin
                m_owner = acc;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic drain(input int vp, input int rp, input int maxc, output int n);
        n = 0;
        while ((pending() || m_out.valid || m_owner >= 0) && n < maxc) begin
            cycle(vp, rp);
            n++;
        end
        if (pending() || m_out.valid || m_owner >= 0) chk("drain_timeout", 32'd1, 32'd0);
    endtask

    task automatic rst_chk(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        chk({tag, "_out"}, 32'(out_flit), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_grant"}, 32'(grant_idx), 32'd0);
        chk({tag, "_err"}, 32'(err_len), 32'd0);
    endtask

    initial begin
        int      n;
        dii_flit f;
        rst = 1'b0; out_ready = 1'b1; mute = '0; err_pulses = 0;
        in_flit = '0;
        for (int p = 0; p < NP; p++) in_flit[p].valid = 1'b1;
        m_reset();
        @(posedge clk); #1;
        rst_chk("reset");
        rst = 1'b1;

        // port 2 alone: fixed three-flit packet
        for (int i = 0; i < 3; i++) begin
            f.valid = 1'b1; f.last = (i == 2); f.data = 16'hA001 + 16'(i);
            pq[2].push_back(f);
        end
        drain(100, 100, 20, n);

        // all ports, 2-flit packets, back to back with no bubble
        for (int r = 0; r < 2; r++) for (int p = 0; p < NP; p++) add_pkt(p, 2);
        drain(100, 100, 100, n);
        chk("b2b_cycles", 32'(n), 32'd17);

        // backpressure for 5 cycles mid-packet
        add_pkt(1, 8); add_pkt(3, 3);
        for (int i = 0; i < 3; i++) cycle(100, 100);
        for (int i = 0; i < 5; i++) cycle(100, 0);
        drain(100, 100, 100, n);

        // lock hold: granted port goes quiet while port 1 requests
        add_pkt(0, 5); add_pkt(1, 2);
        m_next = m_next;
        for (int i = 0; i < 2; i++) cycle(100, 100);
        mute = 4'b0001;
        for (int i = 0; i < 3; i++) cycle(100, 100);
        mute = '0;
        drain(100, 100, 100, n);

        // overlong packet
        err_pulses = 0;
        add_pkt(0, 14); add_pkt(1, 3);
        drain(100, 100, 100, n);
        chk("err_pulses", 32'(err_pulses), 32'd1);

        // random mix
        for (int i = 0; i < 40; i++) add_pkt(int'($urandom_range(NP - 1)), int'($urandom_range(15, 1)));
        drain(70, 70, 5000, n);
        for (int i = 0; i < 20; i++) add_pkt(int'($urandom_range(NP - 1)), int'($urandom_range(6, 1)));
        drain(90, 50, 5000, n);

        // asynchronous reset while a packet holds the lock
        add_pkt(0, 10);
        for (int i = 0; i < 4; i++) cycle(100, 100);
        chk("pre_reset_busy", 32'(busy), 32'd1);
        #1 rst = 1'b0;
        #1 rst_chk("async_reset");
        m_reset();
        for (int p = 0; p < NP; p++) pq[p].delete();
        @(posedge clk); #1;
        rst_chk("reset_hold");
        rst = 1'b1;
        add_pkt(3, 2);
        drain(100, 100, 20, n);
        chk("port3_cycles", 32'(n), 32'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/dii_packet_arbiter.md
Name: dii_packet_arbiter

Overview:
- Round-robin, packet-granular arbiter that shares one DII debug port among NUM_PORTS on-chip debug modules.
- Typical use: feeding the local_in of the ring gateway, or the host-interface DII input, from several modules.
- Once a port is granted, the grant stays on that port until its flit with last=1 has been accepted. Packets are never interleaved.
- Output is registered through a single-entry output stage.

Parameters:
- NUM_PORTS, 2, number of requesting DII inputs; must be at least 2.
- MAX_PKT_LEN, 12, expected maximum packet length in flits; used only for the overlong-packet check.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous reset, active-low.
- in_flit  input  dii_flit[NUM_PORTS-1:0]  requester flits; each carries valid, last and data[15:0].
- in_ready  output  NUM_PORTS  per-port accept.
- out_flit  output  dii_flit  arbitrated output; registered.
- out_ready  input  1  downstream accept.
- grant_idx  output  $clog2(NUM_PORTS)  port currently locked; holds the last grant when idle.
- busy  output  1  high while in LOCKED.
- err_len  output  1  one-cycle pulse when a packet exceeds MAX_PKT_LEN.

Behaviour:
- Reset (rst=0, async):
  - out_flit.valid=0, out_flit.last=0, out_flit.data=0.
  - state=IDLE; rr_ptr=0; grant_idx=0; pkt_cnt=0; busy=0; err_len=0.
  - in_ready=0 while rst=0.
- Output slot:
  - slot_free = !out_flit.valid | out_ready.
  - A flit accepted in cycle N appears on out_flit in cycle N+1 (latency 1).
  - Full throughput: one flit per cycle while out_ready=1.
  - out_flit holds its value and valid until out_ready=1.
  - The slot is cleared (valid=0) after a transfer if no new flit is loaded in the same cycle.
- IDLE state:
  - sel = first port with in_flit[i].valid=1, searching rr_ptr, rr_ptr+1, ... mod NUM_PORTS.
  - If a request exists and slot_free: in_ready[sel]=1 combinationally, all other in_ready=0. The flit is accepted the same cycle, so there is no arbitration bubble.
  - grant_idx<=sel; pkt_cnt<=1.
  - If the accepted flit has last=1: stay in IDLE and set rr_ptr<=sel+1 mod NUM_PORTS (single-flit packet).
  - Otherwise: go to LOCKED.
  - With no request, or slot not free: all in_ready=0 and no state change.
- LOCKED state:
  - in_ready[grant_idx] = slot_free; all other in_ready=0.
  - The granted port dropping valid mid-packet is legal. The lock is held indefinitely; other ports wait.
  - Each accepted flit increments pkt_cnt; the counter saturates at MAX_PKT_LEN+1.
  - Accepted flit with last=1: go to IDLE, rr_ptr<=grant_idx+1 mod NUM_PORTS, pkt_cnt<=0.
- busy = (state==LOCKED).
- err_len:
  - One-cycle pulse in the cycle after the acceptance that takes pkt_cnt from MAX_PKT_LEN to MAX_PKT_LEN+1 with last=0.
  - Fires at most once per packet.
  - Lock and data are unaffected; no flit is dropped or modified.
- Fairness:
  - The port granted last has the lowest priority in the next arbitration.
  - With all ports continuously requesting, grants rotate 0,1,...,NUM_PORTS-1,0.
- Simultaneous events: last flit accepted while other ports request. The next packet may start in the very next cycle (back-to-back). The new grant uses the updated rr_ptr.
- Reset mid-packet: the partial packet is discarded from the arbiter's view (output slot cleared), and arbitration restarts from port 0. Downstream recovery is out of scope.
- Data integrity: out_flit is a bit-exact copy of the accepted in_flit, including last.

Test Plan:
- Single port, NUM_PORTS=4: port 2 sends 3 flits (0xA001, 0xA002, 0xA003 with last) while out_ready=1.
  - out_flit shows them in cycles N+1 to N+3.
  - in_ready=4'b0100 during the transfer; rr_ptr ends at 3.
- All 4 ports each hold a 2-flit packet continuously.
  - Output packet order is 0,1,2,3,0.
  - Never interleaved; no idle cycle between packets.
- Backpressure: out_ready=0 for 5 cycles mid-packet.
  - out_flit stable; in_ready[grant]=0 after the slot fills.
  - On release, flits resume with none lost or duplicated.
- Lock hold: the granted port drops valid for 3 cycles mid-packet while port 1 requests.
  - Port 1 is not granted until the granted port's last flit is accepted.
- Overlong packet, MAX_PKT_LEN=12: a 14-flit packet on port 0.
  - err_len pulses exactly once, in the cycle after the 13th flit is accepted.
  - All 14 flits are forwarded intact.
- Async reset asserted mid-packet (busy=1).
  - Outputs go to their reset values immediately (out_flit.valid=0, busy=0).
  - After release, the first request from port 3 alone is granted in 1 cycle.
